// File: rtl/drac_pkg.sv
// rtl/drac_pkg.sv - shared rename-stage types and sizes
//
// Purpose: physical-tag, checkpoint-label and free-list pointer types used by
// the rename table and the free list so both agree on widths and labels.
// Ports: none (package).

package drac_pkg;

  localparam int NUM_PHYSICAL_REGISTERS = 64;
  localparam int NUM_ISA_REGISTERS      = 32;
  localparam int NUM_CHECKPOINTS        = 4;

  // Ring depth must be a power of two so the extended pointer wraps cleanly.
  localparam int FL_DEPTH = NUM_PHYSICAL_REGISTERS - NUM_ISA_REGISTERS;

  localparam int PHREG_W  = $clog2(NUM_PHYSICAL_REGISTERS);
  localparam int CKPT_W   = $clog2(NUM_CHECKPOINTS);
  localparam int FL_IDX_W = $clog2(FL_DEPTH);

  typedef logic [PHREG_W-1:0]  phreg_t;
  typedef logic [CKPT_W-1:0]   checkpoint_ptr;

  // Ring index plus one wrap bit: head - tail then spans 0..FL_DEPTH.
  typedef logic [FL_IDX_W:0]   fl_ptr_t;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;

  function automatic fl_idx_t fl_index(input fl_ptr_t ptr);
    return ptr[FL_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename-side connection to the physical-register free list
//
// Purpose: bundles the pop, release, checkpoint and recovery controls with the
// show-ahead tag and status flags.
// Modports:
//   master - rename/commit side: drives requests, observes tag and flags
//   slave  - free list: consumes requests, drives tag and flags
// Signals:
//   read_head_i           pop one tag this cycle
//   add_free_register_i   per-port release valid (port 0 older)
//   free_register_i       released tags
//   do_checkpoint_i       snapshot head after this cycle's pop
//   do_recover_i          restore snapshot recover_checkpoint_i
//   recover_checkpoint_i  snapshot label to restore
//   delete_checkpoint_i   retire oldest snapshot
//   recover_commit_i      exception flush
//   new_register_o        tag at head, 0 when empty
//   checkpoint_o          current version label
//   out_of_checkpoints_o  no snapshot slot left
//   empty_o               no free tag

interface free_list_if;
  import drac_pkg::*;

  logic                read_head_i;
  logic [1:0]          add_free_register_i;
  phreg_t [1:0]        free_register_i;
  logic                do_checkpoint_i;
  logic                do_recover_i;
  checkpoint_ptr       recover_checkpoint_i;
  logic                delete_checkpoint_i;
  logic                recover_commit_i;
  phreg_t              new_register_o;
  checkpoint_ptr       checkpoint_o;
  logic                out_of_checkpoints_o;
  logic                empty_o;

  modport master (
    output read_head_i, add_free_register_i, free_register_i,
           do_checkpoint_i, do_recover_i, recover_checkpoint_i,
           delete_checkpoint_i, recover_commit_i,
    input  new_register_o, checkpoint_o, out_of_checkpoints_o, empty_o
  );

  modport slave (
    input  read_head_i, add_free_register_i, free_register_i,
           do_checkpoint_i, do_recover_i, recover_checkpoint_i,
           delete_checkpoint_i, recover_commit_i,
    output new_register_o, checkpoint_o, out_of_checkpoints_o, empty_o
  );

endinterface

// File: rtl/free_list_ckpt_ctrl.sv
// rtl/free_list_ckpt_ctrl.sv - checkpoint version head/tail/count bookkeeping
//
// Purpose: tracks live snapshot labels exactly as the rename table does, so a
// label handed out here names the same version in both structures.
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   do_checkpoint_i          request a new snapshot
//   do_recover_i             roll back to recover_checkpoint_i
//   recover_checkpoint_i     label to roll back to
//   delete_checkpoint_i      retire the oldest snapshot
//   recover_commit_i         flush: all versions collapse to 0
//   ckpt_en_o                snapshot accepted this cycle
//   snap_slot_o              slot the accepted snapshot is written into
//   version_head_o           current version label
//   out_of_checkpoints_o     all usable slots are taken

module free_list_ckpt_ctrl
  import drac_pkg::*;
(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          do_checkpoint_i,
  input  logic          do_recover_i,
  input  checkpoint_ptr recover_checkpoint_i,
  input  logic          delete_checkpoint_i,
  input  logic          recover_commit_i,
  output logic          ckpt_en_o,
  output checkpoint_ptr snap_slot_o,
  output checkpoint_ptr version_head_o,
  output logic          out_of_checkpoints_o
);

  // One slot always holds the live version, so only N-1 can be outstanding.
  localparam checkpoint_ptr LAST_COUNT = checkpoint_ptr'(NUM_CHECKPOINTS - 1);

  checkpoint_ptr version_head_q, version_head_d;
  checkpoint_ptr version_tail_q, version_tail_d;
  checkpoint_ptr count_q, count_d;
  checkpoint_ptr tail_after_delete;

  always_comb begin
    ckpt_en_o = do_checkpoint_i & (count_q < LAST_COUNT)
              & ~do_recover_i & ~recover_commit_i;
    tail_after_delete = version_tail_q + checkpoint_ptr'(delete_checkpoint_i);

    version_head_d = version_head_q;
    version_tail_d = version_tail_q;
    count_d        = count_q;

    if (recover_commit_i) begin
      version_head_d = '0;
      version_tail_d = '0;
      count_d        = '0;
    end else if (do_recover_i) begin
      // Live versions after rollback run from the (possibly just advanced)
      // tail up to the restored label; modular subtraction handles wrap.
      version_head_d = recover_checkpoint_i;
      version_tail_d = tail_after_delete;
      count_d        = recover_checkpoint_i - tail_after_delete;
    end else begin
      if (ckpt_en_o) begin
        version_head_d = version_head_q + checkpoint_ptr'(1);
      end
      version_tail_d = tail_after_delete;
      count_d        = count_q + checkpoint_ptr'(ckpt_en_o)
                     - checkpoint_ptr'(delete_checkpoint_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      version_head_q <= '0;
      version_tail_q <= '0;
      count_q        <= '0;
    end else begin
      version_head_q <= version_head_d;
      version_tail_q <= version_tail_d;
      count_q        <= count_d;
    end
  end

  assign snap_slot_o          = version_head_q + checkpoint_ptr'(1);
  assign version_head_o       = version_head_q;
  assign out_of_checkpoints_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - speculative physical-register free list with head snapshots
//
// Purpose: ring of free physical tags. Rename pops from the head (show-ahead),
// commit returns up to two tags per cycle at the tail, and per-checkpoint
// copies of the head pointer let branch recovery and exception flush undo
// speculative pops.
// Ports:
//   clk_i   clock
//   rstn_i  asynchronous active-low reset
//   fl      free_list_if.slave - requests in, head tag and status out

module free_list
  import drac_pkg::*;
(
  input  logic         clk_i,
  input  logic         rstn_i,
  free_list_if.slave   fl
);

  phreg_t  ram_q  [FL_DEPTH];
  fl_ptr_t snap_q [NUM_CHECKPOINTS];

  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t in_flight;

  logic    empty;
  logic    pop;
  logic    valid0, valid1;
  logic    we0, we1;
  phreg_t  wdata0, wdata1;

  logic          ckpt_en;
  checkpoint_ptr snap_slot;
  checkpoint_ptr version_head;
  logic          out_of_checkpoints;

  free_list_ckpt_ctrl u_ckpt_ctrl (
    .clk_i                (clk_i),
    .rstn_i               (rstn_i),
    .do_checkpoint_i      (fl.do_checkpoint_i),
    .do_recover_i         (fl.do_recover_i),
    .recover_checkpoint_i (fl.recover_checkpoint_i),
    .delete_checkpoint_i  (fl.delete_checkpoint_i),
    .recover_commit_i     (fl.recover_commit_i),
    .ckpt_en_o            (ckpt_en),
    .snap_slot_o          (snap_slot),
    .version_head_o       (version_head),
    .out_of_checkpoints_o (out_of_checkpoints)
  );

  // Tags popped but not yet returned; the wrap bit makes a full ring of
  // outstanding tags distinguishable from none.
  assign in_flight = head_q - tail_q;
  assign empty     = (in_flight == fl_ptr_t'(FL_DEPTH));

  assign pop = fl.read_head_i & ~empty & ~fl.do_recover_i & ~fl.recover_commit_i;

  // Tag 0 is never a real release, and a flush returns every in-flight tag
  // by moving the head, so releases in that cycle are dropped.
  assign valid0 = fl.add_free_register_i[0] & (fl.free_register_i[0] != '0)
                & ~fl.recover_commit_i;
  assign valid1 = fl.add_free_register_i[1] & (fl.free_register_i[1] != '0)
                & ~fl.recover_commit_i;

  always_comb begin
    // Compact valid releases into consecutive slots starting at the tail.
    we0    = valid0 | valid1;
    wdata0 = valid0 ? fl.free_register_i[0] : fl.free_register_i[1];
    we1    = valid0 & valid1;
    wdata1 = fl.free_register_i[1];
    tail_d = tail_q + fl_ptr_t'(valid0) + fl_ptr_t'(valid1);

    if (fl.recover_commit_i) begin
      head_d = tail_q;
    end else if (fl.do_recover_i) begin
      head_d = snap_q[fl.recover_checkpoint_i];
    end else begin
      head_d = head_q + fl_ptr_t'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        ram_q[i] <= phreg_t'(NUM_ISA_REGISTERS + i);
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (we0) begin
        ram_q[fl_index(tail_q)] <= wdata0;
      end
      if (we1) begin
        ram_q[fl_index(tail_q + fl_ptr_t'(1))] <= wdata1;
      end
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Snapshot includes this cycle's pop, matching the rename table, which
  // records the new mapping in the same cycle it takes the tag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      if (ckpt_en) begin
        snap_q[snap_slot] <= head_d;
      end
      if (fl.recover_commit_i) begin
        snap_q[0] <= tail_q;
      end
    end
  end

  assign fl.new_register_o       = empty ? '0 : ram_q[fl_index(head_q)];
  assign fl.empty_o              = empty;
  assign fl.checkpoint_o         = version_head;
  assign fl.out_of_checkpoints_o = out_of_checkpoints;

  // Returning more tags than were handed out means commit is broken.
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rstn_i) in_flight <= fl_ptr_t'(FL_DEPTH)
  );

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed self-checking bench for free_list

module tb_free_list;
  import drac_pkg::*;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  free_list_if fl_bus ();

  free_list dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .fl     (fl_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fl_bus.read_head_i          = 1'b0;
    fl_bus.add_free_register_i  = 2'b00;
    fl_bus.free_register_i[0]   = '0;
    fl_bus.free_register_i[1]   = '0;
    fl_bus.do_checkpoint_i      = 1'b0;
    fl_bus.do_recover_i         = 1'b0;
    fl_bus.recover_checkpoint_i = '0;
    fl_bus.delete_checkpoint_i  = 1'b0;
    fl_bus.recover_commit_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_n(input int n);
    fl_bus.read_head_i = 1'b1;
    repeat (n) tick();
    fl_bus.read_head_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rstn = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_new_register", fl_bus.new_register_o, 32);
    chk("rst_checkpoint", fl_bus.checkpoint_o, 0);
    chk("rst_out_of_ckpt", fl_bus.out_of_checkpoints_o, 0);
    chk("rst_empty", fl_bus.empty_o, 0);
    rstn = 1'b1;
    tick();

    // Three back-to-back pops, show-ahead
    fl_bus.read_head_i = 1'b1;
    chk("pop0", fl_bus.new_register_o, 32);
    tick();
    chk("pop1", fl_bus.new_register_o, 33);
    tick();
    chk("pop2", fl_bus.new_register_o, 34);
    tick();
    fl_bus.read_head_i = 1'b0;
    chk("after_pop3", fl_bus.new_register_o, 35);
    tick();
    chk("hold_no_pop", fl_bus.new_register_o, 35);

    // Drain to empty
    pop_n(29);
    chk("drained_empty", fl_bus.empty_o, 1);
    chk("drained_tag_zero", fl_bus.new_register_o, 0);
    pop_n(1);
    chk("pop_while_empty_ignored", fl_bus.empty_o, 1);

    // Lone port-1 release while empty
    fl_bus.add_free_register_i = 2'b10;
    fl_bus.free_register_i[0]  = 20;
    fl_bus.free_register_i[1]  = 5;
    chk("free_not_bypassed", fl_bus.empty_o, 1);
    tick();
    idle();
    chk("port1_free_empty", fl_bus.empty_o, 0);
    chk("port1_free_tag", fl_bus.new_register_o, 5);

    // Pop last entry with a concurrent release
    fl_bus.read_head_i         = 1'b1;
    fl_bus.add_free_register_i = 2'b01;
    fl_bus.free_register_i[0]  = 6;
    chk("last_entry_tag", fl_bus.new_register_o, 5);
    tick();
    idle();
    chk("pop_free_one_entry_empty", fl_bus.empty_o, 0);
    chk("pop_free_one_entry_tag", fl_bus.new_register_o, 6);

    // Asynchronous reset mid-operation
    rstn = 1'b0;
    #2;
    chk("async_rst_tag", fl_bus.new_register_o, 32);
    tick();
    rstn = 1'b1;
    tick();

    // Checkpoint while popping 40, then recover to label 1
    pop_n(8);
    chk("before_ckpt_tag", fl_bus.new_register_o, 40);
    fl_bus.read_head_i     = 1'b1;
    fl_bus.do_checkpoint_i = 1'b1;
    tick();
    fl_bus.do_checkpoint_i = 1'b0;
    chk("ckpt_label", fl_bus.checkpoint_o, 1);
    chk("ckpt_next_tag", fl_bus.new_register_o, 41);
    pop_n(2);
    chk("spec_pops_tag", fl_bus.new_register_o, 43);
    fl_bus.read_head_i           = 1'b1;
    fl_bus.do_recover_i          = 1'b1;
    fl_bus.recover_checkpoint_i  = 1;
    fl_bus.add_free_register_i   = 2'b01;
    fl_bus.free_register_i[0]    = 7;
    tick();
    idle();
    chk("recover_tag", fl_bus.new_register_o, 41);
    chk("recover_label", fl_bus.checkpoint_o, 1);
    chk("recover_out_of_ckpt", fl_bus.out_of_checkpoints_o, 0);
    pop_n(23);
    chk("recover_free_enqueued", fl_bus.new_register_o, 7);
    chk("recover_not_empty", fl_bus.empty_o, 0);

    // Exception flush drops concurrent free
    do_reset();
    pop_n(9);
    fl_bus.read_head_i     = 1'b1;
    fl_bus.do_checkpoint_i = 1'b1;
    tick();
    idle();
    chk("pre_flush_label", fl_bus.checkpoint_o, 1);
    fl_bus.add_free_register_i = 2'b11;
    fl_bus.free_register_i[0]  = 32;
    fl_bus.free_register_i[1]  = 33;
    tick();
    fl_bus.free_register_i[0]  = 34;
    fl_bus.free_register_i[1]  = 35;
    tick();
    idle();
    fl_bus.recover_commit_i    = 1'b1;
    fl_bus.add_free_register_i = 2'b01;
    fl_bus.free_register_i[0]  = 9;
    fl_bus.read_head_i         = 1'b1;
    fl_bus.do_checkpoint_i     = 1'b1;
    tick();
    idle();
    chk("flush_label", fl_bus.checkpoint_o, 0);
    chk("flush_out_of_ckpt", fl_bus.out_of_checkpoints_o, 0);
    chk("flush_empty", fl_bus.empty_o, 0);
    chk("flush_free_dropped_tag", fl_bus.new_register_o, 36);
    fl_bus.do_recover_i         = 1'b1;
    fl_bus.recover_checkpoint_i = 0;
    tick();
    idle();
    chk("snap0_after_flush_tag", fl_bus.new_register_o, 36);
    chk("snap0_after_flush_label", fl_bus.checkpoint_o, 0);
    pop_n(31);
    chk("flush_full_ring_tag", fl_bus.new_register_o, 35);
    chk("flush_full_ring_not_empty", fl_bus.empty_o, 0);
    pop_n(1);
    chk("flush_full_ring_empty", fl_bus.empty_o, 1);

    // Checkpoint exhaustion, delete, recover with same-cycle delete
    do_reset();
    fl_bus.do_checkpoint_i = 1'b1;
    tick();
    tick();
    chk("two_ckpt_not_out", fl_bus.out_of_checkpoints_o, 0);
    tick();
    chk("three_ckpt_out", fl_bus.out_of_checkpoints_o, 1);
    chk("three_ckpt_label", fl_bus.checkpoint_o, 3);
    tick();
    idle();
    chk("fourth_ckpt_ignored_label", fl_bus.checkpoint_o, 3);
    chk("fourth_ckpt_still_out", fl_bus.out_of_checkpoints_o, 1);
    fl_bus.delete_checkpoint_i = 1'b1;
    tick();
    idle();
    chk("delete_clears_out", fl_bus.out_of_checkpoints_o, 0);
    chk("delete_keeps_label", fl_bus.checkpoint_o, 3);
    fl_bus.do_recover_i         = 1'b1;
    fl_bus.recover_checkpoint_i = 2;
    fl_bus.delete_checkpoint_i  = 1'b1;
    tick();
    idle();
    chk("recover_del_label", fl_bus.checkpoint_o, 2);
    chk("recover_del_out", fl_bus.out_of_checkpoints_o, 0);
    fl_bus.do_checkpoint_i = 1'b1;
    tick();
    tick();
    chk("recount_two_label", fl_bus.checkpoint_o, 0);
    chk("recount_two_not_out", fl_bus.out_of_checkpoints_o, 0);
    tick();
    idle();
    chk("recount_three_label", fl_bus.checkpoint_o, 1);
    chk("recount_three_out", fl_bus.out_of_checkpoints_o, 1);

    // Tag 0 release is ignored, tag 12 compacts to tail
    pop_n(32);
    chk("tag0_pre_empty", fl_bus.empty_o, 1);
    fl_bus.add_free_register_i = 2'b11;
    fl_bus.free_register_i[0]  = 0;
    fl_bus.free_register_i[1]  = 12;
    tick();
    idle();
    chk("tag0_not_empty", fl_bus.empty_o, 0);
    chk("tag0_compacted_tag", fl_bus.new_register_o, 12);
    pop_n(1);
    chk("tag0_tail_plus_one", fl_bus.empty_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
